cmp_counter: RTL and testbench

//   Loadable compare counter with a shared bidirectional value bus. Counts down to 0
//   (decrease mode) or up to a compare value (increase mode), then auto-restarts.

---
 rtl/cmp_counter.sv | 93 +++++++++
 tb/tb_cmp_counter.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/cmp_counter.sv
// Loadable up/down compare counter with a shared bidirectional value bus.
// Counts to its terminal value, flags it on o_match, then restarts on the next edge.
module cmp_counter #(
  parameter int WIDTH = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  inout  wire [WIDTH-1:0]  io_value,
  output logic             o_match,
  input  logic             i_restart,
  input  logic [1:0]       i_setup
);

  typedef enum logic {
    MODE_INC = 1'b0,
    MODE_DEC = 1'b1
  } mode_t;

  localparam logic [1:0]       SETUP_RUN    = 2'b00;
  localparam logic [1:0]       SETUP_LD_INC = 2'b01;
  localparam logic [1:0]       SETUP_PRESET = 2'b10;
  localparam logic [1:0]       SETUP_LD_DEC = 2'b11;
  localparam logic [WIDTH-1:0] ZERO         = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONES         = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ONE          = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] r_cnt;
  logic [WIDTH-1:0] r_ref;
  mode_t            r_mode;

  logic [WIDTH-1:0] w_cnt_next;
  logic [WIDTH-1:0] w_ref_next;
  mode_t            w_mode_next;
  logic             w_run;
  logic             w_term;

  assign w_run    = (i_setup == SETUP_RUN);
  assign w_term   = (r_mode == MODE_DEC) ? (r_cnt == ZERO) : (r_cnt == r_ref);
  // Bus is owned by the counter only in run mode; setup modes turn it around at once.
  assign io_value = w_run ? r_cnt : {WIDTH{1'bz}};
  assign o_match  = w_run & w_term & i_rst_n;

  // Next-state selection: any setup code overrides restart and counting.
  always_comb begin
    w_cnt_next  = r_cnt;
    w_ref_next  = r_ref;
    w_mode_next = r_mode;
    case (i_setup)
      SETUP_LD_DEC: begin
        w_ref_next  = io_value;
        w_cnt_next  = io_value;
        w_mode_next = MODE_DEC;
      end
      SETUP_LD_INC: begin
        w_ref_next  = io_value;
        w_cnt_next  = ZERO;
        w_mode_next = MODE_INC;
      end
      SETUP_PRESET: begin
        w_cnt_next = io_value;
      end
      SETUP_RUN: begin
        if (i_restart || w_term) begin
          w_cnt_next = (r_mode == MODE_DEC) ? r_ref : ZERO;
        end else if (r_mode == MODE_DEC) begin
          w_cnt_next = r_cnt - ONE;
        end else begin
          // Increase mode wraps modulo 2^WIDTH when preset above the compare value.
          w_cnt_next = r_cnt + ONE;
        end
      end
      default: begin
        w_cnt_next  = r_cnt;
        w_ref_next  = r_ref;
        w_mode_next = r_mode;
      end
    endcase
  end

  // State registers with asynchronous reset to a full-range down count.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt  <= ONES;
      r_ref  <= ONES;
      r_mode <= MODE_DEC;
    end else begin
      r_cnt  <= w_cnt_next;
      r_ref  <= w_ref_next;
      r_mode <= w_mode_next;
    end
  end

endmodule

// File: tb/tb_cmp_counter.sv
// Directed bench for cmp_counter (WIDTH=4): a per-cycle reference model compared on
// every falling edge, plus literal expected bus/match sequences.
module tb_cmp_counter;
  localparam int W = 4;

  logic         clk     = 1'b0;
  logic         rst_n   = 1'b0;
  logic         restart = 1'b0;
  logic [1:0]   setup   = 2'b00;
  logic [W-1:0] drv     = 4'h0;
  logic         oe      = 1'b0;
  wire  [W-1:0] bus;
  wire          match;

  assign bus = oe ? drv : {W{1'bz}};

  cmp_counter #(.WIDTH(W)) dut (
    .i_clk    (clk),
    .i_rst_n  (rst_n),
    .io_value (bus),
    .o_match  (match),
    .i_restart(restart),
    .i_setup  (setup)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: count, compare value and direction as plain integers.
  int m_cnt = 15;
  int m_ref = 15;
  bit m_dec = 1'b1;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cnt <= 15; m_ref <= 15; m_dec <= 1'b1;
    end else if (setup == 2'b11) begin
      m_cnt <= int'(drv); m_ref <= int'(drv); m_dec <= 1'b1;
    end else if (setup == 2'b01) begin
      m_cnt <= 0; m_ref <= int'(drv); m_dec <= 1'b0;
    end else if (setup == 2'b10) begin
      m_cnt <= int'(drv);
    end else if (restart) begin
      m_cnt <= m_dec ? m_ref : 0;
    end else if (m_dec) begin
      m_cnt <= (m_cnt == 0) ? m_ref : m_cnt - 1;
    end else begin
      m_cnt <= (m_cnt == m_ref) ? 0 : (m_cnt + 1) % 16;
    end
  end

  task automatic check(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h, expected %0h", nm, $time, act, exp);
    end
  endtask

  // Compare process: every falling edge, outputs against the model.
  always @(negedge clk) begin
    int exp_bus;
    int exp_m;
    if (!rst_n) begin
      exp_m   = 0;
      exp_bus = (setup == 2'b00) ? 15 : int'(drv);
    end else begin
      exp_bus = (setup == 2'b00) ? m_cnt : int'(drv);
      exp_m   = (setup == 2'b00) && (m_dec ? (m_cnt == 0) : (m_cnt == m_ref)) ? 1 : 0;
    end
    check("model_bus", int'(bus), exp_bus);
    check("model_match", int'(match), exp_m);
  end

  // One run cycle with a hand-computed expected bus value and match.
  task automatic run_chk(input logic [W-1:0] b, input logic m, input logic rs = 1'b0);
    setup = 2'b00; oe = 1'b0; restart = rs;
    @(negedge clk);
    check("lit_bus", int'(bus), int'(b));
    check("lit_match", int'(match), int'(m));
    @(posedge clk); #1;
    restart = 1'b0;
  endtask

  // One setup cycle: bench owns the bus, match must be low.
  task automatic setup_cyc(input logic [1:0] code, input logic [W-1:0] v);
    setup = code; oe = 1'b1; drv = v;
    @(negedge clk);
    check("setup_bus", int'(bus), int'(v));
    check("setup_match", int'(match), 0);
    @(posedge clk); #1;
    setup = 2'b00; oe = 1'b0;
  endtask

  initial begin
    logic [W-1:0] v;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Default after reset: F down to 0, match at 0, then F again.
    for (int i = 15; i >= 0; i--) begin
      v = 4'(i);
      run_chk(v, (i == 0));
    end
    run_chk(4'hF, 1'b0);

    // Load-dec 3: period of 4.
    setup_cyc(2'b11, 4'h3);
    run_chk(4'h3, 1'b0); run_chk(4'h2, 1'b0); run_chk(4'h1, 1'b0); run_chk(4'h0, 1'b1);
    run_chk(4'h3, 1'b0); run_chk(4'h2, 1'b0); run_chk(4'h1, 1'b0); run_chk(4'h0, 1'b1);

    // Load-inc 2.
    setup_cyc(2'b01, 4'h2);
    run_chk(4'h0, 1'b0); run_chk(4'h1, 1'b0); run_chk(4'h2, 1'b1); run_chk(4'h0, 1'b0);

    // Restart mid-count reloads the compare value.
    setup_cyc(2'b11, 4'h5);
    run_chk(4'h5, 1'b0); run_chk(4'h4, 1'b0); run_chk(4'h3, 1'b0);
    run_chk(4'h2, 1'b0, 1'b1);
    run_chk(4'h5, 1'b0); run_chk(4'h4, 1'b0);

    // Compare value 0 in both modes: match every run cycle.
    setup_cyc(2'b11, 4'h0);
    run_chk(4'h0, 1'b1); run_chk(4'h0, 1'b1); run_chk(4'h0, 1'b1);
    setup_cyc(2'b01, 4'h0);
    run_chk(4'h0, 1'b1); run_chk(4'h0, 1'b1);

    // Asynchronous reset mid-count.
    setup_cyc(2'b11, 4'h9);
    run_chk(4'h9, 1'b0); run_chk(4'h8, 1'b0); run_chk(4'h7, 1'b0);
    rst_n = 1'b0;
    #1;
    check("rst_bus", int'(bus), 15);
    check("rst_match", int'(match), 0);
    @(posedge clk); #1 rst_n = 1'b1;
    run_chk(4'hF, 1'b0); run_chk(4'hE, 1'b0);

    // Increase mode preset above compare: wraps through 0, preset masks match.
    setup_cyc(2'b01, 4'h2);
    run_chk(4'h0, 1'b0); run_chk(4'h1, 1'b0);
    setup_cyc(2'b10, 4'hE);
    run_chk(4'hE, 1'b0); run_chk(4'hF, 1'b0); run_chk(4'h0, 1'b0);
    run_chk(4'h1, 1'b0); run_chk(4'h2, 1'b1); run_chk(4'h0, 1'b0);

    @(posedge clk); #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
